// File: rtl/pipe_adc_correct.sv
// Pipelined ADC digital correction: per-stage thermometer encoding,
// stage alignment, weighted overlap-add with saturation, sticky bubble flags.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   therm_in   NSTAGE*TW thermometer slices, slice 0 (LSBs) is the MSB stage
//   in_valid   stage-0 sample of a new conversion is present this cycle
//   err_clr    clears err_stage (a same-edge new error still sets its bit)
//   out_data   corrected, registered result (held while out_valid is low)
//   out_valid  one-cycle pulse per conversion
//   out_sat    out_data was clamped to full scale
//   err_stage  sticky per-stage bubble-error flags
module pipe_adc_correct #(
    parameter int NSTAGE      = 5,
    parameter int TW          = 6,
    parameter int BUBBLE_MODE = 0,
    localparam int B          = $clog2(TW + 1),
    localparam int OUT_W      = NSTAGE * (B - 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NSTAGE*TW-1:0] therm_in,
    input  logic                 in_valid,
    input  logic                 err_clr,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_sat,
    output logic [NSTAGE-1:0]    err_stage
);

    localparam int SW = OUT_W + B;

    logic [NSTAGE-1:0]        w_v;
    logic [NSTAGE-1:1]        r_v;
    logic [NSTAGE-1:0][B-1:0] w_code;
    logic [NSTAGE-1:0][B-1:0] w_al;
    logic [NSTAGE-1:0]        w_err;
    logic [SW-1:0]            w_sum;
    logic                     w_ovf;

    logic [OUT_W-1:0]         r_data;
    logic                     r_valid;
    logic                     r_sat;
    logic [NSTAGE-1:0]        r_err;

    // w_v[k] is in_valid delayed k cycles: it qualifies slice k this cycle
    assign w_v = {r_v, in_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
        end else begin
            r_v <= w_v[NSTAGE-2:0];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_st
        localparam int D = NSTAGE - 1 - k;

        logic [TW-1:0] w_th;
        logic [B-1:0]  w_pop;
        logic          w_bad;

        assign w_th = therm_in[k*TW +: TW];

        always_comb begin
            w_pop = '0;
            for (int i = 0; i < TW; i++) begin
                w_pop = w_pop + B'(w_th[i]);
            end
        end

        // Legal codes are 0..01..1; adding one to them clears every set bit
        assign w_bad = |(w_th & (w_th + TW'(1)));

        assign w_code[k] = (w_bad && BUBBLE_MODE == 0) ? B'(TW) : w_pop;
        assign w_err[k]  = w_v[k] & w_bad;

        // Later stages arrive later, so they need fewer alignment registers
        if (D == 0) begin : g_nodly
            assign w_al[k] = w_code[k];
        end else begin : g_dly
            logic [B-1:0] r_sr [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        r_sr[i] <= '0;
                    end
                end else begin
                    r_sr[0] <= w_code[k];
                    for (int i = 1; i < D; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign w_al[k] = r_sr[D-1];
        end
    end

    // Overlapping stages: each stage weighs 2^(B-1) less than the one above
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            w_sum = w_sum + (SW'(w_al[k]) << ((NSTAGE - 1 - k) * (B - 1)));
        end
    end

    assign w_ovf = |w_sum[SW-1:OUT_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_valid <= w_v[NSTAGE-1];
            if (w_v[NSTAGE-1]) begin
                r_data <= w_ovf ? '1 : w_sum[OUT_W-1:0];
                r_sat  <= w_ovf;
            end
        end
    end

    // A new error on the clearing edge still sets its own bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err <= (err_clr ? '0 : r_err) | w_err;
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign out_sat   = r_sat;
    assign err_stage = r_err;

endmodule

// File: tb/tb_pipe_adc_correct.sv
// Self-checking bench for pipe_adc_correct: three instances (default,
// BUBBLE_MODE=1, TW=7) driven from a cycle plan and checked every cycle.
module tb_pipe_adc_correct;

    localparam int N = 5;
    localparam int L = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             err_clr;
    logic [N*6-1:0]   therm0;
    logic [N*7-1:0]   therm2;
    logic [2:0][10:0] od;
    logic [2:0]       ov;
    logic [2:0]       os;
    logic [2:0][4:0]  oe;

    int total = 0;
    int bad = 0;

    bit         iv  [L];
    bit         clr [L];
    logic [5:0] th0 [L][N];
    logic [6:0] th2 [L][N];

    int         e_data [3];
    bit         e_sat  [3];
    bit         e_v    [3];
    logic [4:0] e_err  [3];

    always #5 clk = ~clk;

    pipe_adc_correct u0 (
        .clk(clk), .rst(rst), .therm_in(therm0), .in_valid(in_valid),
        .err_clr(err_clr), .out_data(od[0]), .out_valid(ov[0]),
        .out_sat(os[0]), .err_stage(oe[0])
    );

    pipe_adc_correct #(.BUBBLE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .therm_in(therm0), .in_valid(in_valid),
        .err_clr(err_clr), .out_data(od[1]), .out_valid(ov[1]),
        .out_sat(os[1]), .err_stage(oe[1])
    );

    pipe_adc_correct #(.TW(7)) u2 (
        .clk(clk), .rst(rst), .therm_in(therm2), .in_valid(in_valid),
        .err_clr(err_clr), .out_data(od[2]), .out_valid(ov[2]),
        .out_sat(os[2]), .err_stage(oe[2])
    );

    function automatic int tw_of(input int d);
        return (d == 2) ? 7 : 6;
    endfunction

    function automatic bit is_legal(input int x, input int tw);
        for (int n = 0; n <= tw; n++) begin
            if (x == (1 << n) - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int ones(input int x);
        int s = 0;
        for (int i = 0; i < 32; i++) s += (x >> i) & 1;
        return s;
    endfunction

    function automatic int enc(input int x, input int d);
        if (is_legal(x, tw_of(d))) return ones(x);
        return (d == 1) ? ones(x) : tw_of(d);
    endfunction

    function automatic int thv(input int d, input int c, input int k);
        if (d < 2) return int'(th0[c][k]);
        return int'(th2[c][k]);
    endfunction

    function automatic logic [34:0] pk(input int a, input int b,
                                       input int c, input int d,
                                       input int e);
        return {7'(e), 7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    function automatic int rnd_slice();
        int n;
        if ($urandom_range(0, 5) == 0) return int'($urandom_range(0, 127));
        n = int'($urandom_range(0, 7));
        return (1 << n) - 1;
    endfunction

    task automatic chk(input string tag, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < 3; d++) begin
            e_data[d] = 0;
            e_sat[d]  = 1'b0;
            e_v[d]    = 1'b0;
            e_err[d]  = '0;
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_valid"}, d, 32'(ov[d]), 32'd0);
            chk({tag, "_data"}, d, 32'(od[d]), 32'd0);
            chk({tag, "_sat"}, d, 32'(os[d]), 32'd0);
            chk({tag, "_err"}, d, 32'(oe[d]), 32'd0);
        end
    endtask

    task automatic clear_plan(input bit junk);
        logic [31:0] r;
        for (int c = 0; c < L; c++) begin
            iv[c]  = 1'b0;
            clr[c] = 1'b0;
            for (int k = 0; k < N; k++) begin
                r = $urandom;
                th0[c][k] = junk ? r[5:0] : 6'd0;
                th2[c][k] = junk ? r[6:0] : 7'd0;
            end
        end
    endtask

    task automatic launch(input int t, input logic [34:0] p);
        iv[t] = 1'b1;
        for (int k = 0; k < N; k++) begin
            th2[t+k][k] = p[k*7 +: 7];
            th0[t+k][k] = p[k*7 +: 6];
        end
    endtask

    task automatic run(input int len, input string tag);
        int s;
        int t;
        for (int c = 0; c < len; c++) begin
            in_valid = iv[c];
            err_clr  = clr[c];
            for (int k = 0; k < N; k++) begin
                therm0[k*6 +: 6] = th0[c][k];
                therm2[k*7 +: 7] = th2[c][k];
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (clr[c]) e_err[d] = '0;
                for (int k = 0; k < N; k++) begin
                    if (c >= k && iv[c-k] && !is_legal(thv(d, c, k), tw_of(d)))
                        e_err[d][k] = 1'b1;
                end
                e_v[d] = (c >= N - 1) && iv[c-(N-1)];
                if (e_v[d]) begin
                    t = c - (N - 1);
                    s = 0;
                    for (int k = 0; k < N; k++)
                        s += enc(thv(d, t + k, k), d) * (1 << (2 * (N - 1 - k)));
                    e_sat[d]  = (s > 2047);
                    e_data[d] = e_sat[d] ? 2047 : s;
                end
                chk({tag, "_valid"}, c, 32'(ov[d]), 32'(e_v[d]));
                chk({tag, "_data"}, c, 32'(od[d]), 32'(e_data[d]));
                chk({tag, "_sat"}, c, 32'(os[d]), 32'(e_sat[d]));
                chk({tag, "_err"}, c, 32'(oe[d]), 32'(e_err[d]));
            end
        end
        in_valid = 1'b0;
        err_clr  = 1'b0;
        therm0   = '0;
        therm2   = '0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        therm0   = '0;
        therm2   = '0;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        clear_plan(1'b0);
        launch(2, pk(7, 7, 7, 7, 7));
        run(12, "align");
        chk("align_1023", 0, 32'(od[0]), 32'd1023);
        chk("align_1023_tw7", 0, 32'(od[2]), 32'd1023);

        clear_plan(1'b0);
        launch(1, pk(63, 0, 0, 0, 0));
        run(9, "wmsb");
        chk("w_1536", 0, 32'(od[0]), 32'd1536);

        clear_plan(1'b0);
        launch(1, pk(0, 0, 0, 0, 1));
        run(9, "wlsb");
        chk("w_1", 0, 32'(od[0]), 32'd1);

        clear_plan(1'b1);
        for (int i = 0; i < 8; i++) begin
            launch(2 + i, pk(rnd_slice(), rnd_slice(), rnd_slice(),
                             rnd_slice(), rnd_slice()));
        end
        run(20, "b2b");

        clear_plan(1'b0);
        clr[0] = 1'b1;
        launch(2, pk(0, 0, 21, 0, 0));
        run(10, "bub");
        chk("bub_m0_data", 0, 32'(od[0]), 32'd96);
        chk("bub_m1_data", 0, 32'(od[1]), 32'd48);
        chk("bub_err", 0, 32'(oe[0]), 32'h04);

        clear_plan(1'b0);
        launch(1, pk(0, 5, 0, 0, 0));
        clr[2] = 1'b1;
        run(10, "bclr");
        chk("bclr_err", 0, 32'(oe[0]), 32'h02);

        clear_plan(1'b0);
        launch(1, pk(127, 127, 127, 127, 127));
        run(10, "sat");
        chk("sat_data", 0, 32'(od[2]), 32'd2047);
        chk("sat_flag", 0, 32'(os[2]), 32'd1);
        chk("nosat_data", 0, 32'(od[0]), 32'd2046);

        clear_plan(1'b1);
        launch(1, pk(3, 7, 1, 15, 0));
        launch(2, pk(1, 1, 1, 1, 1));
        launch(3, pk(63, 31, 15, 7, 3));
        clr[0] = 1'b1;
        run(4, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        reset_model();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_plan(1'b0);
        launch(0, pk(7, 7, 7, 7, 7));
        run(12, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_adc_correct.md
PIPE_ADC_CORRECT -- requirements
Module: pipe_adc_correct

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, the number of ADC stages (2..8).
REQ-002 SHALL have parameter TW, default 6, the thermometer width per stage (3..15); B = clog2(TW+1) is the per-stage code width.
REQ-003 SHALL have parameter BUBBLE_MODE, default 0: 0 = an invalid code clamps to TW; 1 = an invalid code encodes as its ones-count.
REQ-004 SHALL derive OUT_W = NSTAGE*(B-1)+1 (default 11).
REQ-005 SHALL use one clock, clk; reset rst is asynchronous and active-high.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 therm_in  input  NSTAGE*TW  slice k = bits [k*TW+TW-1 : k*TW]; stage 0 is MSB stage.
REQ-009 in_valid  input  1  marks stage-0 sample of a new conversion in the current cycle.
REQ-010 err_clr  input  1  clears err_stage.
REQ-011 out_data  output  OUT_W  corrected, registered conversion result.
REQ-012 out_valid  output  1  out_data is a new result this cycle (one-cycle pulse per conversion).
REQ-013 out_sat  output  1  qualifies out_data; high when the sum was saturated.
REQ-014 err_stage  output  NSTAGE  sticky per-stage bubble-error flags.

Function
REQ-015 Conversion timing: for in_valid high in cycle t, slice k SHALL be sampled at the rising edge ending cycle t+k.
REQ-016 Each slice SHALL be encoded combinationally: a legal code (exactly n low ones, 0<=n<=TW) gives n; any other pattern gives TW (mode 0) or popcount (mode 1).
REQ-017 Slice k's code SHALL be delayed by NSTAGE-1-k registers so all NSTAGE codes of one conversion are aligned in cycle t+NSTAGE-1.
REQ-018 A valid token SHALL travel an NSTAGE-deep shift register alongside; v[k] = in_valid delayed k cycles qualifies slice k.
REQ-019 Correction SHALL be a true sum: S = sum over k of code_k * 2^((NSTAGE-1-k)*(B-1)), computed at OUT_W+B bits without truncation.
REQ-020 If S > 2^OUT_W-1, out_data SHALL be 2^OUT_W-1 and out_sat 1; else out_data = S and out_sat 0.
REQ-021 out_data, out_sat, out_valid SHALL be registered at the edge ending cycle t+NSTAGE-1; latency in_valid to out_valid = NSTAGE cycles.
REQ-022 out_data and out_sat SHALL hold their value when out_valid is low.
REQ-023 in_valid in consecutive cycles SHALL be supported at full throughput, one result per cycle, in order.
REQ-024 err_stage[k] SHALL set when slice k is sampled with v[k]=1 and the pattern is illegal; it holds until err_clr or rst.
REQ-025 err_clr and a new error on the same edge: the set SHALL win for that bit; other bits clear.
REQ-026 Slices sampled with v[k]=0 SHALL NOT affect err_stage or any output.

Reset
REQ-027 rst high SHALL asynchronously clear all delay registers, the valid shift register, out_data, out_sat, out_valid and err_stage to 0.
REQ-028 Conversions in flight at reset SHALL be discarded; the first out_valid after release SHALL come exactly NSTAGE cycles after the first post-release in_valid.
REQ-029 Reset deassertion SHALL be treated as synchronous to clk; no output changes on the release edge.

Verification (defaults NSTAGE=5, TW=6, B=3, OUT_W=11)
REQ-030 Reset: rst pulse mid-stream -> all outputs 0 immediately, no out_valid for in-flight conversions, first new out_valid 5 cycles after in_valid.
REQ-031 Alignment: in_valid at t, slice k = 000111 at cycle t+k, all other cycles 000000 -> out_valid at t+5, out_data = 3*341 = 1023, out_sat 0.
REQ-032 Weighting: only slice 0 = 111111 at t, others 0 -> out_data = 1536; only slice 4 = 000001 at t+4 -> out_data = 1.
REQ-033 Back-to-back: in_valid for 8 consecutive cycles with distinct codes -> 8 consecutive out_valid pulses, each equal to the model sum, in order.
REQ-034 Bubble: slice 2 = 010101 at t+2, mode 0 -> code 6, err_stage = 00100; mode 1 -> code 3; err_clr in the same cycle as a new slice-1 error -> err_stage = 00010.
REQ-035 Saturation: TW=7, all slices 1111111 -> S = 7*341 = 2387 -> out_data = 2047, out_sat 1.
